// File: rtl/train_phase_sequencer_if.sv
// Control/status bundle between the training sequencer and its host/datapath.
interface train_phase_sequencer_if #(
  parameter int LAYER_W = 2
);
  logic               start;
  logic               stride;
  logic               infer;
  logic               stall;
  logic               abort;
  logic [1:0]         phase;
  logic [LAYER_W-1:0] layer;
  logic               select0;
  logic               select1;
  logic               busy;
  logic               step_done;
  logic               fp_complete;
  logic               bp_complete;
  logic               done;

  modport master (
    output start, stride, infer, stall, abort,
    input  phase, layer, select0, select1, busy, step_done,
           fp_complete, bp_complete, done
  );

  modport slave (
    input  start, stride, infer, stall, abort,
    output phase, layer, select0, select1, busy, step_done,
           fp_complete, bp_complete, done
  );
endinterface

// File: rtl/train_phase_sequencer.sv
// Training-phase controller: FP over layers 0..N-1, then BP/WG pairs over
// layers N-1..0, with stride-2 FP, inference-only, stall and abort.
module train_phase_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int CNT_W      = 16,
  parameter int FP_LEN     = 4,
  parameter int BP_LEN     = 4,
  parameter int WG_LEN     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  train_phase_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FP,
    BP,
    WG,
    DONE
  } state_t;

  // Last counter value of each step; stride-2 FP rounds the length up.
  localparam logic [CNT_W-1:0]   FP_LAST_S0 = CNT_W'(FP_LEN - 1);
  localparam logic [CNT_W-1:0]   FP_LAST_S1 = CNT_W'((FP_LEN + 1) / 2 - 1);
  localparam logic [CNT_W-1:0]   BP_LAST    = CNT_W'(BP_LEN - 1);
  localparam logic [CNT_W-1:0]   WG_LAST    = CNT_W'(WG_LEN - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stride_q, stride_d;
  logic               infer_q, infer_d;

  logic [CNT_W-1:0]   cnt_last;
  logic               active;
  logic               step_done;

  // State, layer, counter and run-configuration latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      cnt_q    <= '0;
      stride_q <= 1'b0;
      infer_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      cnt_q    <= cnt_d;
      stride_q <= stride_d;
      infer_q  <= infer_d;
    end
  end

  // Step length for the current phase and the end-of-step condition.
  always_comb begin
    cnt_last = '0;
    active   = 1'b0;
    case (state_q)
      FP: begin
        cnt_last = stride_q ? FP_LAST_S1 : FP_LAST_S0;
        active   = 1'b1;
      end
      BP: begin
        cnt_last = BP_LAST;
        active   = 1'b1;
      end
      WG: begin
        cnt_last = WG_LAST;
        active   = 1'b1;
      end
      default: ;
    endcase
    step_done = active && (cnt_q == cnt_last) && !bus.stall;
  end

  // Next-state logic; abort overrides everything except reset.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    cnt_d    = cnt_q;
    stride_d = stride_q;
    infer_d  = infer_q;

    if (bus.abort) begin
      state_d = IDLE;
      layer_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            stride_d = bus.stride;
            infer_d  = bus.infer;
            state_d  = FP;
            layer_d  = '0;
            cnt_d    = '0;
          end
        end
        FP, BP, WG: begin
          if (!bus.stall) begin
            if (step_done) begin
              cnt_d = '0;
              case (state_q)
                FP: begin
                  if (layer_q != LAST_LAYER) begin
                    layer_d = layer_q + 1'b1;
                  end else if (infer_q) begin
                    state_d = DONE;
                  end else begin
                    state_d = BP;
                  end
                end
                BP: state_d = WG;
                default: begin
                  if (layer_q != '0) begin
                    state_d = BP;
                    layer_d = layer_q - 1'b1;
                  end else begin
                    state_d = DONE;
                  end
                end
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          layer_d = '0;
        end
        default: begin
          state_d = IDLE;
          layer_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Datapath selects, phase code and completion pulses.
  always_comb begin
    bus.phase = 2'd0;
    case (state_q)
      FP:      bus.phase = 2'd1;
      BP:      bus.phase = 2'd2;
      WG:      bus.phase = 2'd3;
      default: bus.phase = 2'd0;
    endcase
    bus.layer       = layer_q;
    bus.select0     = (state_q == FP);
    bus.select1     = (state_q == WG);
    bus.busy        = active;
    bus.step_done   = step_done;
    bus.fp_complete = step_done && (state_q == FP) && (layer_q == LAST_LAYER);
    bus.bp_complete = step_done && (state_q == WG) && (layer_q == '0);
    bus.done        = (state_q == DONE);
  end

endmodule

// File: tb/tb_train_phase_sequencer.sv
// Bench for train_phase_sequencer: three configurations share one stimulus
// stream; a step-list reference model checks every cycle, plus a cycle table
// and directed multi-cycle scenarios.
module tb_train_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stride, infer, stall, abort;

  train_phase_sequencer_if #(.LAYER_W(2)) ifa ();
  train_phase_sequencer_if #(.LAYER_W(2)) ifb ();
  train_phase_sequencer_if #(.LAYER_W(2)) ifc ();

  assign ifa.start = start;  assign ifa.stride = stride; assign ifa.infer = infer;
  assign ifa.stall = stall;  assign ifa.abort  = abort;
  assign ifb.start = start;  assign ifb.stride = stride; assign ifb.infer = infer;
  assign ifb.stall = stall;  assign ifb.abort  = abort;
  assign ifc.start = start;  assign ifc.stride = stride; assign ifc.infer = infer;
  assign ifc.stall = stall;  assign ifc.abort  = abort;

  train_phase_sequencer #(.NUM_LAYERS(2), .LAYER_W(2), .CNT_W(16),
    .FP_LEN(4), .BP_LEN(4), .WG_LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  train_phase_sequencer #(.NUM_LAYERS(2), .LAYER_W(2), .CNT_W(16),
    .FP_LEN(5), .BP_LEN(4), .WG_LEN(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  train_phase_sequencer #(.NUM_LAYERS(1), .LAYER_W(2), .CNT_W(16),
    .FP_LEN(1), .BP_LEN(1), .WG_LEN(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [1:0] phase;
    logic [1:0] layer;
    logic       sel0;
    logic       sel1;
    logic       busy;
    logic       sd;
    logic       fpc;
    logic       bpc;
    logic       done;
  } obs_t;

  obs_t live_a, live_b, live_c;
  assign live_a = {ifa.phase, ifa.layer, ifa.select0, ifa.select1, ifa.busy,
                   ifa.step_done, ifa.fp_complete, ifa.bp_complete, ifa.done};
  assign live_b = {ifb.phase, ifb.layer, ifb.select0, ifb.select1, ifb.busy,
                   ifb.step_done, ifb.fp_complete, ifb.bp_complete, ifb.done};
  assign live_c = {ifc.phase, ifc.layer, ifc.select0, ifc.select1, ifc.busy,
                   ifc.step_done, ifc.fp_complete, ifc.bp_complete, ifc.done};

  int checks = 0;
  int failures = 0;
  int tcyc = 0;
  bit cmp_en = 1'b0;
  obs_t cur [3];
  obs_t hist [0:63];

  // Reference model: a run is a list of steps {phase, layer, length}.
  typedef struct {
    int ph;
    int ly;
    int len;
    bit fpl;
    bit bpl;
  } step_t;

  step_t stp [3][16];
  int nst [3];
  int head [3];
  int el [3];
  int lastly [3];
  bit indone [3];
  int nl_v [3] = '{2, 2, 1};
  int fp_v [3] = '{4, 5, 1};
  int bp_v [3] = '{4, 4, 1};
  int wg_v [3] = '{4, 4, 1};

  task automatic add_step(input int d, input int ph, input int ly, input int len,
                          input bit fpl, input bit bpl);
    stp[d][nst[d]].ph  = ph;
    stp[d][nst[d]].ly  = ly;
    stp[d][nst[d]].len = len;
    stp[d][nst[d]].fpl = fpl;
    stp[d][nst[d]].bpl = bpl;
    nst[d]++;
  endtask

  task automatic build_run(input int d, input bit s, input bit inf);
    int fpeff;
    fpeff = s ? (fp_v[d] + 1) / 2 : fp_v[d];
    nst[d] = 0; head[d] = 0; el[d] = 0; indone[d] = 1'b0;
    for (int l = 0; l < nl_v[d]; l++)
      add_step(d, 1, l, fpeff, (l == nl_v[d] - 1), 1'b0);
    if (!inf) begin
      for (int l = nl_v[d] - 1; l >= 0; l--) begin
        add_step(d, 2, l, bp_v[d], 1'b0, 1'b0);
        add_step(d, 3, l, wg_v[d], 1'b0, (l == 0));
      end
    end
  endtask

  function automatic obs_t model_exp(input int d);
    obs_t o;
    step_t s;
    o = '0;
    if (head[d] < nst[d]) begin
      s = stp[d][head[d]];
      o.phase = 2'(s.ph);
      o.layer = 2'(s.ly);
      o.busy  = 1'b1;
      o.sel0  = (s.ph == 1);
      o.sel1  = (s.ph == 3);
      o.sd    = !stall && (el[d] == s.len - 1);
      o.fpc   = o.sd && s.fpl;
      o.bpc   = o.sd && s.bpl;
    end else if (indone[d]) begin
      o.layer = 2'(lastly[d]);
      o.done  = 1'b1;
    end
    return o;
  endfunction

  task automatic model_step(input int d);
    if (rst || abort) begin
      nst[d] = 0; head[d] = 0; el[d] = 0; indone[d] = 1'b0;
    end else if (head[d] < nst[d]) begin
      if (!stall) begin
        if (el[d] == stp[d][head[d]].len - 1) begin
          lastly[d] = stp[d][head[d]].ly;
          head[d]++;
          el[d] = 0;
          if (head[d] == nst[d]) indone[d] = 1'b1;
        end else begin
          el[d]++;
        end
      end
    end else if (indone[d]) begin
      indone[d] = 1'b0;
    end else if (start) begin
      build_run(d, stride, infer);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One clock: sample/compare at negedge, advance model at posedge.
  task automatic cycle();
    obs_t e;
    @(negedge clk);
    cur[0] = live_a; cur[1] = live_b; cur[2] = live_c;
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        e = model_exp(d);
        chk_obs($sformatf("model_d%0d_t%0d", d, tcyc), cur[d], e);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    tcyc++;
  endtask

  task automatic reset_all();
    rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    stride = 1'b0; infer = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // Start a run at cycle 0 and record one DUT's outputs for cycles 0..maxc.
  task automatic scenario(input int d, input int maxc, input bit s, input bit inf,
                          input int st_lo, input int st_hi, input int abort_at,
                          input int start2, input int rst_at);
    stride = s;
    infer  = inf;
    for (int c = 0; c <= maxc; c++) begin
      start = (c == 0) || (c == start2);
      stall = (c >= st_lo) && (c <= st_hi);
      abort = (c == abort_at);
      rst   = (c == rst_at);
      if (c > 0) stride = ~stride;
      cycle();
      hist[c] = cur[d];
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  function automatic int first_of(input int kind, input int maxc);
    logic f;
    for (int c = 0; c <= maxc; c++) begin
      case (kind)
        0:       f = hist[c].fpc;
        1:       f = hist[c].bpc;
        2:       f = hist[c].done;
        default: f = hist[c].sd;
      endcase
      if (f) return c;
    end
    return -1;
  endfunction

  // Cycle table for the N=2, LEN=4 training run (configuration A).
  typedef struct {
    bit   start;
    bit   stride;
    obs_t exp;
  } vec_t;

  vec_t vec [27];

  task automatic seg(input int lo, input int hi, input int ph, input int ly,
                     input bit fpc, input bit bpc);
    for (int i = lo; i <= hi; i++) begin
      vec[i].exp       = '0;
      vec[i].exp.phase = 2'(ph);
      vec[i].exp.layer = 2'(ly);
      vec[i].exp.busy  = 1'b1;
      vec[i].exp.sel0  = (ph == 1);
      vec[i].exp.sel1  = (ph == 3);
      vec[i].exp.sd    = (i == hi);
      vec[i].exp.fpc   = fpc && (i == hi);
      vec[i].exp.bpc   = bpc && (i == hi);
    end
  endtask

  initial begin
    int c_ph [5];
    int cnt;
    c_ph = '{0, 1, 2, 3, 0};

    for (int i = 0; i < 27; i++) begin
      vec[i].start  = 1'b0;
      vec[i].stride = 1'(i % 2);
      vec[i].exp    = '0;
    end
    seg(1, 4, 1, 0, 1'b0, 1'b0);
    seg(5, 8, 1, 1, 1'b1, 1'b0);
    seg(9, 12, 2, 1, 1'b0, 1'b0);
    seg(13, 16, 3, 1, 1'b0, 1'b0);
    seg(17, 20, 2, 0, 1'b0, 1'b0);
    seg(21, 24, 3, 0, 1'b0, 1'b1);
    vec[25].exp.done = 1'b1;
    vec[0].start  = 1'b1;
    vec[10].start = 1'b1;
    vec[25].start = 1'b1;

    for (int d = 0; d < 3; d++) begin
      nst[d] = 0; head[d] = 0; el[d] = 0; indone[d] = 1'b0; lastly[d] = 0;
    end

    rst = 1'b1; start = 1'b0; stride = 1'b0; infer = 1'b0;
    stall = 1'b0; abort = 1'b0;
    cycle();
    cmp_en = 1'b1;
    cycle();
    rst = 1'b0;
    chk_obs("reset_a", cur[0], '0);
    chk_obs("reset_c", cur[2], '0);

    // Table-driven training run; start pokes while busy and in DONE.
    for (int i = 0; i < 27; i++) begin
      start  = vec[i].start;
      stride = vec[i].stride;
      cycle();
      chk_obs($sformatf("tbl_c%0d", i), cur[0], vec[i].exp);
      if (i >= 1 && i <= 4) begin
        chk_int($sformatf("len1_phase_c%0d", i), int'(cur[2].phase), c_ph[i]);
        chk_int($sformatf("len1_done_c%0d", i), int'(cur[2].done), (i == 4) ? 1 : 0);
      end
    end
    start = 1'b0;

    // Stride-2 FP on FP_LEN=5: three cycles per FP layer.
    reset_all();
    scenario(1, 30, 1'b1, 1'b0, -1, -1, -1, -1, -1);
    chk_int("stride_first_step", first_of(3, 30), 3);
    chk_int("stride_fp_complete", first_of(0, 30), 6);
    chk_int("stride_bp_complete", first_of(1, 30), 22);
    chk_int("stride_done", first_of(2, 30), 23);

    // Inference-only run.
    reset_all();
    scenario(0, 14, 1'b0, 1'b1, -1, -1, -1, -1, -1);
    chk_int("infer_fp_complete", first_of(0, 14), 8);
    chk_int("infer_done", first_of(2, 14), 9);
    cnt = 0;
    for (int c = 0; c <= 14; c++)
      if (hist[c].phase >= 2'd2 || hist[c].sel1 || hist[c].bpc) cnt++;
    chk_int("infer_no_bp_wg", cnt, 0);
    chk_obs("infer_idle_after", hist[10], '0);

    // Stall for cycles 3..5 inside FP layer 0.
    reset_all();
    scenario(0, 32, 1'b0, 1'b0, 3, 5, -1, -1, -1);
    cnt = 0;
    for (int c = 3; c <= 5; c++) if (hist[c].sd) cnt++;
    chk_int("stall_no_step_done", cnt, 0);
    chk_int("stall_fp0_end", first_of(3, 32), 7);
    chk_int("stall_fp_complete", first_of(0, 32), 11);
    chk_int("stall_done", first_of(2, 32), 28);

    // Abort in BP layer 1, then a fresh start.
    reset_all();
    scenario(0, 16, 1'b0, 1'b0, -1, -1, 10, 12, -1);
    chk_int("abort_was_bp", int'(hist[10].phase), 2);
    chk_obs("abort_idle", hist[11], '0);
    chk_int("abort_no_done", first_of(2, 16), -1);
    chk_int("restart_phase", int'(hist[13].phase), 1);
    chk_int("restart_layer", int'(hist[13].layer), 0);

    // Synchronous reset mid-run.
    reset_all();
    scenario(0, 18, 1'b0, 1'b0, -1, -1, -1, -1, 15);
    chk_int("rst_was_busy", int'(hist[15].busy), 1);
    chk_obs("rst_outputs", hist[16], '0);
    chk_obs("rst_stays_idle", hist[18], '0);

    // Randomized traffic checked against the model on all configurations.
    reset_all();
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      abort  = ($urandom_range(0, 59) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      start  = ($urandom_range(0, 2) == 0);
      stride = 1'($urandom_range(0, 1));
      infer  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/train_phase_sequencer.md
Name: train_phase_sequencer

Overview:
Parametrised training-phase controller for the CNN accelerator. It sequences forward pass (FP) layers 0..N-1, then for each layer N-1..0 runs backward pass (BP) followed by weight gradient (WG). It drives the datapath mux selects and per-step completion flags, replacing the fixed 2-bit FP/BP and WG FSM pair. It adds layer count, per-phase lengths, stride, stall, inference-only and abort support.

Parameters:
NUM_LAYERS, 4, number of layers; must be >= 1.
LAYER_W, 2, width of layer index; 2^LAYER_W must be >= NUM_LAYERS.
CNT_W, 16, step cycle counter width.
FP_LEN, 4, FP cycles per layer at stride 0; must be 1..2^CNT_W-1.
BP_LEN, 4, BP cycles per layer.
WG_LEN, 4, WG cycles per layer.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  begin a run; sampled only in IDLE.
stride  in  1  1 = stride-2 FP; latched at accepted start.
infer  in  1  1 = FP only, skip BP/WG; latched at accepted start.
stall  in  1  freeze the counter and state while high.
abort  in  1  synchronous return to IDLE.
phase  out  2  0 idle/done, 1 FP, 2 BP, 3 WG.
layer  out  LAYER_W  current layer index.
select0  out  1  high while in FP.
select1  out  1  high while in WG.
busy  out  1  high in FP/BP/WG.
step_done  out  1  final cycle of a layer step.
fp_complete  out  1  one-cycle pulse with step_done of the last FP layer.
bp_complete  out  1  one-cycle pulse with step_done of WG on layer 0.
done  out  1  one-cycle pulse in DONE.

Behaviour:
- States: IDLE, FP, BP, WG, DONE. The state, layer, counter, latched stride and latched infer are registers.
- Reset (rst=1 at an edge): state IDLE, layer 0, counter 0, latches 0. Outputs: phase 0, select0/select1/busy/done 0, and step_done/fp_complete/bp_complete 0. Reset mid-run discards the run.
- Reset has priority over abort; abort has priority over stall and start.
- IDLE:
  - start=1 at an edge latches stride and infer.
  - Next cycle: FP, layer 0, counter 0.
- Effective length:
  - FP: FP_LEN at stride 0, (FP_LEN+1)>>1 at stride 1.
  - BP: BP_LEN. WG: WG_LEN.
- Counter behaviour in FP/BP/WG:
  - Counts 0..len-1, advancing only when stall=0.
  - step_done = (counter==len-1) && !stall, combinational from registers.
  - At an edge with step_done=1 the counter resets to 0 and the transition below occurs.
- Transitions on step_done:
  - FP, layer < N-1: FP, layer+1.
  - FP, layer = N-1: fp_complete=1 this cycle. Next is DONE if infer, else BP at layer N-1.
  - BP: WG, same layer.
  - WG, layer > 0: BP, layer-1.
  - WG, layer = 0: bp_complete=1 this cycle; next DONE.
- DONE:
  - Lasts exactly one cycle, with phase 0, done=1 and layer holding its last value.
  - Then IDLE with layer 0.
  - start is ignored in DONE.
- Stall: state, layer and counter hold; step_done, fp_complete and bp_complete are forced 0.
- Abort=1 at an edge in any state: next cycle IDLE, counter 0, layer 0; done is not pulsed.
- start outside IDLE: ignored, no effect.
- Length 1: step_done is high on every non-stalled cycle of that phase.
- Run length with no stalls:
  - Training: N*FPeff + N*(BP_LEN+WG_LEN) busy cycles, then 1 DONE cycle.
  - Inference: N*FPeff busy cycles, then DONE.

Test Plan:
- NUM_LAYERS=2, all LEN=4, start at edge 0, stride=0, infer=0:
  - FP L0 cycles 1-4, FP L1 5-8 (fp_complete at 8).
  - BP L1 9-12, WG L1 13-16, BP L0 17-20.
  - WG L0 21-24 (bp_complete at 24); done at 25; IDLE at 26.
  - select0 high 1-8; select1 high 13-16 and 21-24.
- Same configuration with stride=1 and FP_LEN=5: FP is 3 cycles/layer, fp_complete at cycle 6, done at cycle 23. Toggling stride mid-run changes nothing.
- infer=1, N=2, FP_LEN=4: fp_complete at 8, done at 9, never phase 2/3, select1 always 0.
- stall high for 3 cycles at cycle 3 (FP L0, counter 2):
  - step_done stays 0 while stalled.
  - FP L0 ends at cycle 7 and every later event shifts by 3 (done at 28).
- abort at cycle 10 (BP L1): IDLE at 11, layer 0, busy 0, no done. A new start at 12 begins FP at 13.
- Boundary checks:
  - rst at cycle 15 forces all outputs to reset values at 16.
  - start asserted during busy or DONE is ignored.
  - With all LEN=1 and N=1: FP 1, BP 2, WG 3, done 4.
